grf_scoreboard: RTL and testbench

- General register file for the 5-stage MIPS pipeline: 32 x 32-bit registers, two read ports in D stage, one write port from W stage.
- It is the write-side counterpart to the operand selectors. It decodes the 5-bit destination into one register enable and steers the write-back word into that register.
- A per-register pending bit is set when an instruction issues with a destination and cleared when that destination is written back. D-stage logic uses these bits for stall decisions.
- Internal write-to-read bypass removes the W-to-D forwarding path.

---
 rtl/grf_scoreboard.sv | 99 +++++++++
 tb/tb_grf_scoreboard.sv | 136 +++++++++++++
 2 files changed

// File: rtl/grf_scoreboard.sv
// General register file for the 5-stage pipeline: 32x32 registers, two
// combinational read ports with W->D bypass, one write port, and a
// per-register pending (scoreboard) set with a registered pending count.
module grf_scoreboard #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned NREG         = 32,
    parameter logic [31:0] RESET_PC_TAG = 32'h0000_3000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       A1,
    input  logic [4:0]       A2,
    output logic [WIDTH-1:0] RD1,
    output logic [WIDTH-1:0] RD2,
    input  logic             WE,
    input  logic [4:0]       A3,
    input  logic [WIDTH-1:0] WD,
    input  logic [31:0]      WPC,
    input  logic             IssueEn,
    input  logic [4:0]       IssueA,
    output logic             Busy1,
    output logic             Busy2,
    output logic [5:0]       PendCnt
);

    localparam int unsigned CW = 6;

    logic [WIDTH-1:0] regs [NREG];
    logic [NREG-1:0]  pend;
    logic [NREG-1:0]  pend_next;
    logic [CW-1:0]    cnt_next;
    logic             wr_en;
    logic             set_en;
    logic             inc;
    logic             dec;

    // PC/tag are only meaningful to the write-back tracer, not to the logic.
    logic unused_trace;
    assign unused_trace = ^{WPC, RESET_PC_TAG};

    // Writes to $0 are dropped, as are issues that name $0.
    assign wr_en  = WE && (A3 != 5'd0);
    assign set_en = IssueEn && (IssueA != 5'd0);

    // Register array: clear on reset, single write port; $0 is never written.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[A3] <= WD;
        end
    end

    // Read ports: $0 reads zero, a same-cycle write is bypassed to the reader.
    always_comb begin
        RD1 = '0;
        RD2 = '0;
        if (A1 != 5'd0) begin
            if (WE && (A3 == A1)) RD1 = WD;
            else                  RD1 = regs[A1];
        end
        if (A2 != 5'd0) begin
            if (WE && (A3 == A2)) RD2 = WD;
            else                  RD2 = regs[A2];
        end
    end

    // Pending-set update: clear on write-back, then set on issue so the newer
    // instruction keeps ownership when both target the same register.
    always_comb begin
        pend_next = pend;
        if (wr_en)  pend_next[A3]     = 1'b0;
        if (set_en) pend_next[IssueA] = 1'b1;
        pend_next[0] = 1'b0;
        inc      = set_en && !pend[IssueA];
        dec      = wr_en && pend[A3] && !(set_en && (IssueA == A3));
        cnt_next = PendCnt + CW'(inc) - CW'(dec);
    end

    // Pending bits and their population count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pend    <= '0;
            PendCnt <= '0;
        end else begin
            pend    <= pend_next;
            PendCnt <= cnt_next;
        end
    end

    // A write completing this cycle is served by the bypass, so it does not stall.
    always_comb begin
        Busy1 = pend[A1] && !(WE && (A3 == A1));
        Busy2 = pend[A2] && !(WE && (A3 == A2));
    end

endmodule

// File: tb/tb_grf_scoreboard.sv
// Self-checking bench for grf_scoreboard: a table of per-cycle vectors plus
// hand-built sequences, with expected outputs queued at drive time and
// checked mid-cycle.
module tb_grf_scoreboard;

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic        ie;
        logic [4:0]  ia;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        b1;
        logic        b2;
        logic [5:0]  cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  A1, A2, A3, IssueA;
    logic [31:0] RD1, RD2, WD, WPC;
    logic        WE, IssueEn, Busy1, Busy2;
    logic [5:0]  PendCnt;

    int n_checks = 0;
    int n_fail   = 0;
    int row_id   = 0;
    vec_t exp_q[$];
    vec_t tbl[21];

    grf_scoreboard dut (
        .clk(clk), .reset(reset), .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
        .WE(WE), .A3(A3), .WD(WD), .WPC(WPC), .IssueEn(IssueEn),
        .IssueA(IssueA), .Busy1(Busy1), .Busy2(Busy2), .PendCnt(PendCnt)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic we, input logic [4:0] a3,
                                input logic [31:0] wd, input logic ie, input logic [4:0] ia,
                                input logic [4:0] a1, input logic [4:0] a2,
                                input logic [31:0] rd1, input logic [31:0] rd2,
                                input logic b1, input logic b2, input logic [5:0] cnt);
        vec_t v;
        v.rst = rst; v.we = we; v.a3 = a3; v.wd = wd; v.ie = ie; v.ia = ia;
        v.a1 = a1; v.a2 = a2; v.rd1 = rd1; v.rd2 = rd2; v.b1 = b1; v.b2 = b2;
        v.cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got %h expected %h", name, row_id, got, exp);
        end
    endtask

    // Drive one cycle's inputs just after the edge, check outputs at the negedge.
    task automatic run(input vec_t v);
        vec_t e;
        @(posedge clk);
        #1;
        reset = v.rst; WE = v.we; A3 = v.a3; WD = v.wd; WPC = 32'h0000_3000 + 32'(row_id * 4);
        IssueEn = v.ie; IssueA = v.ia; A1 = v.a1; A2 = v.a2;
        exp_q.push_back(v);
        @(negedge clk);
        e = exp_q.pop_front();
        check("RD1",     RD1,            e.rd1);
        check("RD2",     RD2,            e.rd2);
        check("Busy1",   32'(Busy1),     32'(e.b1));
        check("Busy2",   32'(Busy2),     32'(e.b2));
        check("PendCnt", 32'(PendCnt),   32'(e.cnt));
        row_id++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        //            rst we a3  wd            ie ia   a1  a2  rd1           rd2           b1 b2 cnt
        tbl[0]  = mk(0, 0, 0,  32'h0,        0, 0,  5,  0,  32'h0,        32'h0,        0, 0, 0);
        tbl[1]  = mk(1, 1, 5,  32'hDEADBEEF, 0, 0,  6,  0,  32'h0,        32'h0,        0, 0, 0);
        tbl[2]  = mk(1, 0, 0,  32'h0,        0, 0,  5,  5,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0);
        tbl[3]  = mk(1, 1, 7,  32'h1234,     0, 0,  7,  7,  32'h1234,     32'h1234,     0, 0, 0);
        tbl[4]  = mk(1, 0, 0,  32'h0,        0, 0,  7,  5,  32'h1234,     32'hDEADBEEF, 0, 0, 0);
        tbl[5]  = mk(1, 1, 0,  32'hFFFFFFFF, 1, 0,  0,  0,  32'h0,        32'h0,        0, 0, 0);
        tbl[6]  = mk(1, 0, 0,  32'h0,        0, 0,  0,  7,  32'h0,        32'h1234,     0, 0, 0);
        tbl[7]  = mk(1, 0, 0,  32'h0,        1, 8,  8,  0,  32'h0,        32'h0,        0, 0, 0);
        tbl[8]  = mk(1, 0, 0,  32'h0,        0, 0,  8,  8,  32'h0,        32'h0,        1, 1, 1);
        tbl[9]  = mk(1, 0, 0,  32'h0,        0, 0,  8,  8,  32'h0,        32'h0,        1, 1, 1);
        tbl[10] = mk(1, 1, 8,  32'hAAAA5555, 0, 0,  8,  8,  32'hAAAA5555, 32'hAAAA5555, 0, 0, 1);
        tbl[11] = mk(1, 0, 0,  32'h0,        0, 0,  8,  9,  32'hAAAA5555, 32'h0,        0, 0, 0);
        tbl[12] = mk(1, 0, 0,  32'h0,        1, 9,  9,  0,  32'h0,        32'h0,        0, 0, 0);
        tbl[13] = mk(1, 1, 9,  32'h99,       1, 9,  9,  9,  32'h99,       32'h99,       0, 0, 1);
        tbl[14] = mk(1, 0, 0,  32'h0,        0, 0,  9,  8,  32'h99,       32'hAAAA5555, 1, 0, 1);
        tbl[15] = mk(1, 1, 10, 32'h10,       0, 0,  9,  10, 32'h99,       32'h10,       1, 0, 1);
        tbl[16] = mk(1, 0, 0,  32'h0,        0, 0,  10, 9,  32'h10,       32'h99,       0, 1, 1);
        tbl[17] = mk(1, 1, 9,  32'h77,       1, 11, 11, 9,  32'h0,        32'h77,       0, 0, 1);
        tbl[18] = mk(1, 0, 0,  32'h0,        0, 0,  11, 9,  32'h0,        32'h77,       1, 0, 1);
        tbl[19] = mk(0, 0, 0,  32'h0,        0, 0,  11, 9,  32'h0,        32'h77,       1, 0, 1);
        tbl[20] = mk(1, 0, 0,  32'h0,        0, 0,  11, 9,  32'h0,        32'h0,        0, 0, 0);

        reset = 1'b0; WE = 1'b0; A3 = '0; WD = '0; WPC = '0;
        IssueEn = 1'b0; IssueA = '0; A1 = '0; A2 = '0;
        @(posedge clk);

        for (int i = 0; i < 21; i++) run(tbl[i]);

        // Fill the scoreboard: issue $1..$31 back to back.
        for (int i = 1; i <= 31; i++) begin
            v = mk(1, 0, 0, 32'h0, 1, 5'(i), 5'(i), 5'(i - 1), 32'h0, 32'h0,
                   1'b0, (i > 1), 6'(i - 1));
            run(v);
        end
        run(mk(1, 0, 0, 32'h0, 0, 0, 31, 1, 32'h0, 32'h0, 1, 1, 31));
        run(mk(0, 0, 0, 32'h0, 0, 0, 31, 1, 32'h0, 32'h0, 1, 1, 31));

        // After reset every register reads 0 and nothing is busy.
        for (int i = 0; i < 32; i++) begin
            run(mk(1, 0, 0, 32'h0, 0, 0, 5'(i), 5'(31 - i), 32'h0, 32'h0, 0, 0, 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
